// File: rtl/riscv_mem_arbiter.sv
// ==== riscv_mem_arbiter : round-robin core/loader arbiter for the data memory ====
// rev 1.0
`timescale 1ns/1ps
`default_nettype none

module riscv_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   we_q,    we_d;
  logic   winner;

  // Byte-offset bits and bits above the memory depth never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_W+2], c_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  // Loader wins when alone, or on a tie when the core had the last grant.
  assign winner = l_req & (~c_req | (last_q == PORT_C));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= PORT_C;
      last_q  <= PORT_L;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    l_rvalid  = 1'b0;
    c_rdata   = '0;
    l_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    // Combinational outputs are forced low while reset is held.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (c_req || l_req) begin
            c_gnt     = (winner == PORT_C);
            l_gnt     = (winner == PORT_L);
            mem_en    = 1'b1;
            mem_we    = winner ? l_we : c_we;
            mem_addr  = winner ? l_addr[ADDR_W+1:2] : c_addr[ADDR_W+1:2];
            mem_wdata = winner ? l_wdata : c_wdata;
            state_d   = RESP;
            owner_d   = winner;
            last_d    = winner;
            we_d      = mem_we;
          end
        end
        RESP: begin
          state_d = IDLE;
          if (owner_q == PORT_C) begin
            c_rvalid = 1'b1;
            c_rdata  = we_q ? '0 : mem_rdata;
          end else begin
            l_rvalid = 1'b1;
            l_rdata  = we_q ? '0 : mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-requester arbiter that shares the single-port data memory of the RISC-V processor between the core's load/store unit (port C) and the external program/data loader (port L, the `wEn`/`address` style interface driven by the bench). It serialises accesses with a 2-state FSM and round-robin priority. Each granted access is returned to its owner one cycle later with a response strobe. It sits between the core datapath, the loader, and the memory array.

## Interface
- ADDR_W, 10: memory depth in 32-bit words, so the memory holds 2^ADDR_W words.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- c_req  in  1  core access request; held until c_gnt.
- c_we  in  1  core write enable (1 = store, 0 = load).
- c_addr  in  32  core byte address; bits [1:0] ignored.
- c_wdata  in  32  core store data.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core response strobe, 1 cycle.
- c_rdata  out  32  core load data, valid with c_rvalid.
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: loader port, identical in meaning and width to the c_* port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address = winner addr[ADDR_W+1:2].
- mem_wdata  out  32  winner write data.
- mem_rdata  in  32  memory read data, registered (1-cycle latency after mem_en).

## Operation
- FSM states:
  - IDLE: accepts a new request.
  - RESP: returns the response.
- Reset:
  - Async reset forces state IDLE, owner = C, last = L.
  - While reset is high, every output is 0, including the combinational gnt and mem_* outputs.
- IDLE, no request: stay in IDLE. mem_en = 0 and both gnt = 0.
- IDLE, only one request: that requester wins.
- IDLE, both requesting: the requester not equal to `last` wins (round-robin). After reset the core wins the first tie.
- Win (Mealy, same cycle):
  - gnt of the winner = 1.
  - mem_en = 1.
  - mem_we, mem_addr, mem_wdata are taken from the winner.
  - At the clock edge: owner <= winner, last <= winner, state <= RESP.
- RESP:
  - owner's rvalid = 1.
  - owner's rdata = mem_rdata for a read. For a write, rdata = 0 and rvalid is an acknowledge.
  - No grant is issued. mem_en = 0. Next state is IDLE.
- Loser: its gnt stays 0 and it must hold req and its fields stable. At the latest, it wins in the next IDLE cycle.
- Address bits above ADDR_W+1 are ignored, so the address wraps modulo the memory size.
- The non-owner's rvalid and rdata are always 0.

## Timing
- Request accepted in cycle N:
  - gnt and mem_en are high in N.
  - rvalid and rdata are valid in N+1.
  - Latency is 1 cycle from grant to response.
- Throughput: at most 1 access per 2 cycles.
- Continuous contention alternates grants C, L, C, L… on cycles N, N+2, N+4…
- A requester may reassert req in the same cycle as its rvalid. It is granted in N+2 if uncontested, otherwise it waits 2 more cycles.
- A request that rises during RESP waits for the next IDLE. It is not lost.
- Reset asserted during RESP:
  - The rvalid is dropped immediately.
  - A write already strobed in the previous cycle has been committed by the memory.
  - Arbitration restarts with the core favoured.

## Test plan
- Core read alone:
  - Stimulus: preload mem[4] = 32'hDEADBEEF, then c_req = 1, c_we = 0, c_addr = 32'h10.
  - Required: c_gnt and mem_en high with mem_addr = 4 in N; c_rvalid = 1 and c_rdata = 32'hDEADBEEF in N+1; l_* outputs stay 0.
- Loader write then core read-back:
  - Stimulus: l_we = 1, l_addr = 32'h8, l_wdata = 32'h00000013, followed by a core read of 32'h8.
  - Required: l_rvalid pulses once with l_rdata = 0; the core read returns 32'h00000013.
- Simultaneous requests held high for 8 cycles:
  - Required: grants ordered C, L, C, L at N, N+2, N+4, N+6, with each rvalid on the correct port one cycle after its grant.
- Back-to-back requests from one requester:
  - Stimulus: c_req held high with no loader traffic.
  - Required: c_gnt on every other cycle; mem_en never high on two consecutive cycles.
- Address wrap:
  - Stimulus: c_addr = 32'h00001004 with ADDR_W = 10.
  - Required: mem_addr = 1.
- Reset mid-operation:
  - Stimulus: assert reset in the RESP cycle of a loader read, then release it with both requesting.
  - Required: all outputs 0 immediately on reset; l_rvalid is not issued; the core wins the first grant after release.
